// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frame controller behind a UART receiver.
// Hunts for SYNC_BYTE, then parses CMD, LEN, payload and (optionally) a checksum byte.
// A good frame is held, with cmd_valid high, until cmd_ack is seen.
// Optional feature: define UART_CMD_CHECKSUM_EN to require and check a trailing XOR checksum
// byte, computed over CMD, LEN and the payload.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   cmd_valid          level, a parsed command is held
//   cmd_code, cmd_len  command byte and payload length of the held frame
//   pl_rd_addr/data    combinational payload buffer read port (reads 0 past MAX_LEN)
//   cmd_ack            consumer releases the held command
//   err_pulse/code     one-cycle error strobe; code 01 csum, 10 length, 11 timeout (sticky)
//   drop_pulse         one-cycle strobe, byte discarded while a command is held
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 43400,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1),
  localparam int unsigned ADDR_W      = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] pl_rd_addr,
  output logic [7:0]        pl_rd_data,
  input  logic              cmd_ack,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic              drop_pulse
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StCsum, StHold} state_e;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StHold} state_e;
`endif

  state_e           state;
  logic [7:0]       pl_buf [MAX_LEN];
  logic [LEN_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;
  logic             timeout;

  assign in_frame = (state != StIdle) && (state != StHold);
  // A byte arriving on the expiry cycle is processed instead of timing out.
  assign timeout  = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

  assign pl_rd_data = (32'(pl_rd_addr) < MAX_LEN) ? pl_buf[pl_rd_addr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'h00;
      cmd_len    <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
      drop_pulse <= 1'b0;
      idx        <= '0;
      tmo_cnt    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum       <= 8'h00;
`endif
      for (int i = 0; i < int'(MAX_LEN); i++) pl_buf[i] <= 8'h00;
    end else begin
      err_pulse  <= 1'b0;
      drop_pulse <= 1'b0;

      if (rx_valid || !in_frame || timeout) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;

      if (timeout) begin
        err_pulse <= 1'b1;
        err_code  <= 2'b11;
        state     <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (rx_valid && rx_data == SYNC_BYTE) state <= StCmd;
          end
          StCmd: begin
            if (rx_valid) begin
              cmd_code <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
              csum     <= rx_data;
`endif
              state    <= StLen;
            end
          end
          StLen: begin
            if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
              csum <= csum ^ rx_data;
`endif
              if (32'(rx_data) > MAX_LEN) begin
                err_pulse <= 1'b1;
                err_code  <= 2'b10;
                state     <= StIdle;
              end else begin
                cmd_len <= rx_data[LEN_W-1:0];
                idx     <= '0;
                if (rx_data == 8'h00) begin
`ifdef UART_CMD_CHECKSUM_EN
                  state     <= StCsum;
`else
                  state     <= StHold;
                  cmd_valid <= 1'b1;
`endif
                end else begin
                  state <= StPayload;
                end
              end
            end
          end
          StPayload: begin
            if (rx_valid) begin
              pl_buf[idx[ADDR_W-1:0]] <= rx_data;
              idx                     <= idx + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
              csum                    <= csum ^ rx_data;
`endif
              if (idx == cmd_len - LEN_W'(1)) begin
`ifdef UART_CMD_CHECKSUM_EN
                state     <= StCsum;
`else
                state     <= StHold;
                cmd_valid <= 1'b1;
`endif
              end
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          StCsum: begin
            if (rx_valid) begin
              if (rx_data == csum) begin
                state     <= StHold;
                cmd_valid <= 1'b1;
              end else begin
                err_pulse <= 1'b1;
                err_code  <= 2'b01;
                state     <= StIdle;
              end
            end
          end
`endif
          StHold: begin
            // Every byte seen while holding is discarded, sync included.
            if (rx_valid) drop_pulse <= 1'b1;
            if (cmd_ack) begin
              cmd_valid <= 1'b0;
              state     <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 64;

  typedef struct packed {
    logic [7:0]   code;
    logic [4:0]   len;
    logic [127:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [4:0] cmd_len;
  logic [3:0] pl_rd_addr = 4'h0;
  logic [7:0] pl_rd_data;
  logic       cmd_ack = 1'b0;
  logic       err_pulse;
  logic [1:0] err_code;
  logic       drop_pulse;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] pl [16];
  bit   seen;
  int   drops;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_len    (cmd_len),
    .pl_rd_addr (pl_rd_addr),
    .pl_rd_data (pl_rd_data),
    .cmd_ack    (cmd_ack),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe; returns at the following negedge with its effect visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] code, input int len, input bit expect_ok);
    logic [7:0] c;
    exp_t e;
    c = code ^ 8'(len);
    send_byte(8'hA5);
    send_byte(code);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(pl[i]);
      c = c ^ pl[i];
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(c);
`endif
    if (expect_ok) begin
      e.code = code;
      e.len  = 5'(len);
      e.data = '0;
      for (int i = 0; i < len; i++) e.data[i*8 +: 8] = pl[i];
      sb.push_back(e);
    end
  endtask

  task automatic expect_cmd(input string tag);
    exp_t e;
    int   n = 0;
    while (!cmd_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_code"}, 32'(cmd_code), 32'(e.code));
      chk({tag, "_len"}, 32'(cmd_len), 32'(e.len));
      for (int i = 0; i < int'(e.len); i++) begin
        pl_rd_addr = 4'(i);
        #1;
        chk({tag, "_buf"}, 32'(pl_rd_data), 32'(e.data[i*8 +: 8]));
      end
    end
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk({tag, "_released"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    chk("rst_len", 32'(cmd_len), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_errcode", 32'(err_code), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);

    // Basic frame, with registered latency on the last byte
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h22);
    chk("t1_not_yet", 32'(cmd_valid), 32'd0);
    send_byte(8'h21);
`else
    chk("t1_not_yet", 32'(cmd_valid), 32'd0);
    send_byte(8'h22);
`endif
    chk("t1_latency", 32'(cmd_valid), 32'd1);
    sb.push_back('{code: 8'h10, len: 5'd2, data: 128'h2211});
    expect_cmd("t1");
    repeat (3) @(negedge clk);
    chk("t1_hold", 32'(cmd_valid), 32'd1);
    do_ack("t1");

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h20);
    chk("t2_err", 32'(err_pulse), 32'd1);
    chk("t2_code", 32'(err_code), 32'd1);
    chk("t2_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("t2_one_cycle", 32'(err_pulse), 32'd0);
`endif

    // Length overflow, then length zero and the MAX_LEN boundary
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
    chk("t3_err", 32'(err_pulse), 32'd1);
    chk("t3_code", 32'(err_code), 32'd2);
    @(negedge clk);
    chk("t3_one_cycle", 32'(err_pulse), 32'd0);
    send_frame(8'h07, 0, 1'b1);
    expect_cmd("t3_len0");
    do_ack("t3_len0");
    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h80 + 8'(i * 7));
    send_frame(8'h3C, 16, 1'b1);
    expect_cmd("t3_max");
    do_ack("t3_max");

    // Drops while holding, and a sync on the ack cycle is ignored
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_frame(8'h10, 2, 1'b1);
    expect_cmd("t5_first");
    drops = 0;
    pl[0] = 8'hA5; pl[1] = 8'h33; pl[2] = 8'h01; pl[3] = 8'h44; pl[4] = 8'h32;
    for (int i = 0; i < 5; i++) begin
      send_byte(pl[i]);
      if (drop_pulse) drops++;
    end
    chk("t5_drops", 32'(drops), 32'd5);
    chk("t5_code_frozen", 32'(cmd_code), 32'h10);
    @(negedge clk);
    chk("t5_drop_one_cycle", 32'(drop_pulse), 32'd0);
    @(negedge clk);
    rx_data = 8'hA5; rx_valid = 1'b1; cmd_ack = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; cmd_ack = 1'b0;
    chk("t5_ack_drop", 32'(drop_pulse), 32'd1);
    chk("t5_ack_release", 32'(cmd_valid), 32'd0);
    send_byte(8'h07); send_byte(8'h00);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h07);
`endif
    chk("t5_sync_ignored", 32'(cmd_valid), 32'd0);
    pl[0] = 8'h44;
    send_frame(8'h33, 1, 1'b1);
    expect_cmd("t5_resend");
    do_ack("t5_resend");

    // Inter-byte timeout
    send_byte(8'hA5); send_byte(8'h10);
    seen = 0;
    repeat (TMO - 1) begin
      @(negedge clk);
      if (err_pulse) seen = 1;
    end
    chk("t4_early", 32'(seen), 32'd0);
    @(negedge clk);
    chk("t4_pulse", 32'(err_pulse), 32'd1);
    chk("t4_code", 32'(err_code), 32'd3);
    // Byte arriving TMO-2 cycles after the previous one keeps the frame alive
    send_byte(8'hA5); send_byte(8'h10);
    seen = 0;
    repeat (TMO - 3) begin
      @(negedge clk);
      if (err_pulse) seen = 1;
    end
    send_byte(8'h01);
    if (err_pulse) seen = 1;
    send_byte(8'h55);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h10 ^ 8'h01 ^ 8'h55);
`endif
    chk("t4_no_timeout", 32'(seen), 32'd0);
    sb.push_back('{code: 8'h10, len: 5'd1, data: 128'h55});
    expect_cmd("t4_frame");
    chk("t4_code_sticky", 32'(err_code), 32'd3);
    do_ack("t4");

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h07);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pl_rd_addr = 4'h0;
    #1;
    chk("t6_valid", 32'(cmd_valid), 32'd0);
    chk("t6_code", 32'(cmd_code), 32'd0);
    chk("t6_len", 32'(cmd_len), 32'd0);
    chk("t6_errcode", 32'(err_code), 32'd0);
    chk("t6_buf_cleared", 32'(pl_rd_data), 32'd0);
    pl[0] = 8'hC3; pl[1] = 8'h3C; pl[2] = 8'h99;
    send_frame(8'h42, 3, 1'b1);
    expect_cmd("t6_clean");
    do_ack("t6");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
